// File: rtl/nic.sv
// ---------------------------------------------------------------------------
// nic -- network interface controller between a processing element and the
// PE port of one mesh router.
//
// One single-entry ingress buffer (router -> PE) and one single-entry egress
// buffer (PE -> router). The processor reaches both through a 2-bit-addressed
// register window. An egress packet is injected only in a cycle where the
// router polarity equals the packet's VC bit (bit DATA_WIDTH-1).
//
// Ports:
//   clk           system clock, rising-edge
//   reset         asynchronous active-low reset
//   addr          register select: 00 in data, 01 in status,
//                 10 out data, 11 out status
//   d_in          processor write data
//   d_out         processor read data (registered, 1-cycle latency)
//   nicEn         register access enable
//   nicWrEn       1 = write, 0 = read (qualified by nicEn)
//   net_si/net_di router -> NIC strobe and data
//   net_ri        NIC ready to accept from router
//   net_so/net_do NIC -> router strobe and data
//   net_ro        router ready to accept from NIC
//   net_polarity  router polarity bit
// ---------------------------------------------------------------------------
module nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_ri,
  output logic                  net_so,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_ro,
  input  logic                  net_polarity
);

  localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  logic [DATA_WIDTH-1:0] in_buf_q,  in_buf_d;
  logic                  in_full_q, in_full_d;
  logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
  logic                  out_full_q, out_full_d;
  logic                  drop_q,    drop_d;
  logic [DATA_WIDTH-1:0] d_out_q,   d_out_d;

  logic rd_en;
  logic wr_en;
  logic inject;

  assign rd_en  = nicEn & ~nicWrEn;
  assign wr_en  = nicEn &  nicWrEn;

  // Inject only when the packet's VC bit matches the router's current phase.
  assign inject = out_full_q & net_ro & (net_polarity == out_buf_q[DATA_WIDTH-1]);

  assign net_ri = ~in_full_q;
  assign net_so = inject;
  assign net_do = out_buf_q;
  assign d_out  = d_out_q;

  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    drop_d     = drop_q;
    d_out_d    = d_out_q;

    // Ingress arrival. Cannot coincide with the read-clear below, since the
    // read only clears when full and arrival only happens when empty.
    if (net_si && !in_full_q) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end

    if (rd_en) begin
      unique case (addr)
        ADDR_IN_DATA: begin
          d_out_d = in_buf_q;
          if (in_full_q) in_full_d = 1'b0;
        end
        ADDR_IN_STAT:  d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full_q};
        ADDR_OUT_DATA: d_out_d = out_buf_q;
        ADDR_OUT_STAT: begin
          d_out_d = {{(DATA_WIDTH-2){1'b0}}, drop_q, out_full_q};
          drop_d  = 1'b0;
        end
        default: d_out_d = d_out_q;
      endcase
    end

    // Draining frees the buffer after this edge; a write in the same cycle
    // still sees it full and is dropped.
    if (inject) out_full_d = 1'b0;

    // Placed after the status read so a discard in the same cycle keeps drop set.
    if (wr_en && addr == ADDR_OUT_DATA) begin
      if (!out_full_q) begin
        out_buf_d  = d_in;
        out_full_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
      drop_q     <= 1'b0;
      d_out_q    <= '0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      drop_q     <= drop_d;
      d_out_q    <= d_out_d;
    end
  end

endmodule

// File: tb/tb_nic.sv
// ---------------------------------------------------------------------------
// tb_nic -- scoreboard testbench for nic.
// The driver issues one cycle of stimulus per step and, from a transaction-
// level model of the two mailboxes, pushes the expected read data and the
// expected injected packets into queues. Two monitors pop and compare when
// the DUT presents a read result or an injection strobe.
// ---------------------------------------------------------------------------
module tb_nic;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   addr;
  logic [W-1:0] d_in, d_out, net_di, net_do;
  logic         nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  always #5 clk = ~clk;

  nic #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_di(net_di),
    .net_ri(net_ri), .net_so(net_so), .net_do(net_do), .net_ro(net_ro),
    .net_polarity(net_polarity)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] rd_q[$];
  logic [W-1:0] eg_q[$];

  // Mailbox model: what each buffer holds and whether it holds a packet.
  logic [W-1:0] m_in, m_out;
  bit           m_in_full, m_out_full, m_drop;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_in = '0; m_out = '0; m_in_full = 0; m_out_full = 0; m_drop = 0;
  endtask

  // One clock of stimulus; the model decides what must happen at the next edge.
  task automatic step(input logic si, input logic [W-1:0] di, input logic en,
                      input logic wr, input logic [1:0] a, input logic [W-1:0] din,
                      input logic ro);
    bit was_in_full, was_out_full, send;
    @(negedge clk);
    check("net_ri", {63'b0, net_ri}, {63'b0, ~m_in_full});
    check("net_do", net_do, m_out);
    net_si = si; net_di = di; nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_ro = ro; net_polarity = ~net_polarity;

    was_in_full  = m_in_full;
    was_out_full = m_out_full;
    send = was_out_full && ro && (net_polarity == m_out[W-1]);
    if (send) eg_q.push_back(m_out);

    if (en && !wr) begin
      case (a)
        2'd0: begin rd_q.push_back(m_in); m_in_full = 0; end
        2'd1: rd_q.push_back({63'b0, was_in_full});
        2'd2: rd_q.push_back(m_out);
        default: begin rd_q.push_back({62'b0, m_drop, was_out_full}); m_drop = 0; end
      endcase
    end
    if (si && !was_in_full) begin m_in = di; m_in_full = 1; end
    if (send) m_out_full = 0;
    if (en && wr && a == 2'd2) begin
      if (!was_out_full) begin m_out = din; m_out_full = 1; end
      else m_drop = 1;
    end
  endtask

  task automatic idle(input logic ro);
    step(1'b0, '0, 1'b0, 1'b0, 2'd0, '0, ro);
  endtask

  task automatic rd(input logic [1:0] a, input logic ro);
    step(1'b0, '0, 1'b1, 1'b0, a, '0, ro);
  endtask

  task automatic wr_out(input logic [W-1:0] v, input logic ro);
    step(1'b0, '0, 1'b1, 1'b1, 2'd2, v, ro);
  endtask

  task automatic do_reset();
    @(negedge clk);
    net_si = 0; nicEn = 0; nicWrEn = 0; net_ro = 0;
    reset = 1'b0;
    #1;
    // Asynchronous: outputs clear before any clock edge.
    check("rst_net_ri", {63'b0, net_ri}, 64'd1);
    check("rst_net_so", {63'b0, net_so}, 64'd0);
    check("rst_d_out",  d_out, '0);
    check("rst_net_do", net_do, '0);
    model_clear();
    rd_q.delete();
    eg_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Read monitor: a read sampled at an edge presents d_out just after it.
  initial begin
    bit rd_now;
    forever begin
      @(posedge clk);
      rd_now = (reset === 1'b1) && nicEn && !nicWrEn;
      #1;
      if (rd_now) begin
        if (rd_q.size() == 0) check("d_out_unexpected", d_out, 'x);
        else check("d_out", d_out, rd_q.pop_front());
      end
    end
  end

  // Egress monitor: compares every strobe against the next expected packet.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1 && (net_so === 1'b1 || eg_q.size() != 0)) begin
        check("net_so", {63'b0, net_so}, {63'b0, eg_q.size() != 0});
        if (net_so === 1'b1 && eg_q.size() != 0) check("inject_data", net_do, eg_q.pop_front());
        else if (eg_q.size() != 0) void'(eg_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; net_si = 0; net_di = '0; nicEn = 0; nicWrEn = 0; addr = 0;
    d_in = '0; net_ro = 0; net_polarity = 0;
    model_clear();
    #1;
    check("por_d_out",  d_out, '0);
    check("por_net_ri", {63'b0, net_ri}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Ingress: accept, status, read, ready returns.
    step(1'b1, 64'hA5A5_0000_0000_0001, 0, 0, 2'd0, '0, 0);
    rd(2'd1, 0);
    // Second arrival while full must be ignored.
    step(1'b1, 64'h1111_2222_3333_4444, 0, 0, 2'd0, '0, 0);
    rd(2'd0, 0);
    rd(2'd1, 0);
    rd(2'd0, 0);
    idle(0);

    // Egress with ready: injects only on polarity 1 (VC bit set).
    wr_out(64'h8000_0000_0000_00FF, 1);
    repeat (3) idle(1);
    rd(2'd3, 1);

    // Egress held while router not ready, then drains.
    wr_out(64'h8000_0000_0000_00FF, 0);
    repeat (5) idle(0);
    // Overfill: discarded write, drop then cleared by status read.
    wr_out(64'h0123_4567_89AB_CDEF, 0);
    rd(2'd2, 0);
    rd(2'd3, 0);
    rd(2'd3, 0);
    repeat (3) idle(1);
    rd(2'd3, 1);

    // Both buffers full, then reset mid-run.
    step(1'b1, 64'hDEAD_BEEF_0000_0002, 0, 0, 2'd0, '0, 0);
    wr_out(64'h7000_0000_0000_0003, 0);
    rd(2'd2, 0);
    do_reset();
    rd(2'd1, 0);
    rd(2'd3, 0);
    rd(2'd0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0, {$urandom, $urandom}, $urandom_range(0, 1),
           $urandom_range(0, 1), 2'($urandom_range(0, 3)), {$urandom, $urandom},
           $urandom_range(0, 3) != 0);
    end
    repeat (4) idle(1);

    @(posedge clk);
    #3;
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("eg_q_drained", 64'(eg_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nic.md
# nic

Network interface controller between a processing element and the PE port of one mesh router. It holds one 64-bit ingress buffer (router → PE) and one 64-bit egress buffer (PE → router). It exposes both buffers to the processor through a 2-bit-addressed register interface. Egress injection is gated by the router's polarity, so a packet leaves only in the cycle its virtual-channel bit matches.

## Interface
- DATA_WIDTH, 64, packet width; bit DATA_WIDTH-1 is the VC bit.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- addr  input  2  register select: 00 ingress data, 01 ingress status, 10 egress data, 11 egress status.
- d_in  input  64  processor write data.
- d_out  output  64  processor read data, registered.
- nicEn  input  1  register access enable.
- nicWrEn  input  1  1 = write, 0 = read; meaningful only with nicEn.
- net_si  input  1  router send strobe into NIC (router PE-port send out).
- net_di  input  64  router data into NIC.
- net_ri  output  1  NIC ready to accept from router.
- net_so  output  1  NIC send strobe to router.
- net_do  output  64  NIC data to router.
- net_ro  input  1  router ready to accept from NIC.
- net_polarity  input  1  router polarity bit.

## Operation
- State:
  - in_buf, in_full: ingress buffer and its occupancy flag.
  - out_buf, out_full: egress buffer and its occupancy flag.
  - drop: sticky flag, set when the processor writes the egress buffer while it is full.
- Ingress:
  - net_ri = ~in_full, combinational from the registered flag.
  - When net_si & net_ri at an edge: in_buf <= net_di and in_full <= 1.
  - When net_si arrives while in_full = 1, it is ignored and in_buf is unchanged.
- Processor read (nicEn=1, nicWrEn=0): d_out <= selected value at the edge.
  - addr 00: in_buf. If in_full = 1, in_full <= 0 at the same edge. A read while empty returns stale in_buf with no state change.
  - addr 01: {62'b0, 1'b0, in_full}.
  - addr 10: out_buf; no state change.
  - addr 11: {62'b0, drop, out_full}. The read clears drop.
- Processor write (nicEn=1, nicWrEn=1):
  - addr 10 with out_full = 0: out_buf <= d_in and out_full <= 1.
  - addr 10 with out_full = 1: write discarded, drop <= 1.
  - Writes to addr 00, 01 or 11 have no effect.
- d_out holds its value when there is no read.
- Egress:
  - net_so = out_full & net_ro & (net_polarity == out_buf[63]), combinational.
  - net_do = out_buf at all times.
  - When net_so = 1 at an edge, out_full <= 0.
- Simultaneous events:
  - Egress write and injection in the same cycle: the write sees the pre-edge out_full = 1, is discarded and sets drop. Software must poll status first.
  - Ingress read-clear and router arrival in the same cycle cannot collide, because net_ri = 0 while full.
  - Status read of addr 11 in the same cycle a discarded write sets drop: the set wins, and drop stays 1.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) sets:
  - d_out = 0.
  - in_buf = 0, in_full = 0, so net_ri = 1.
  - out_buf = 0, out_full = 0, so net_so = 0 and net_do = 0.
  - drop = 0.
- Reset mid-transfer discards both buffers; no partial packet survives.
- Read latency: 1 cycle; d_out is valid after the edge that samples nicEn.
- Ingress: a packet is accepted at edge N, and in_full/status is visible to a read sampled at edge N+1. net_ri falls right after edge N.
- Egress:
  - Write at edge N; out_full = 1 from N.
  - Earliest injection edge is N+1, if net_ro = 1 and polarity matches. Otherwise wait; polarity toggles every cycle, so the wait is at most 1 extra cycle while net_ro = 1.
- Throughput: one packet per direction per 2 cycles (fill/drain alternation of a single-entry buffer).

## Test plan
- Reset low mid-run with both buffers full → immediately net_ri=1, net_so=0, d_out=0, net_do=0; status reads after release return 0.
- Router drives net_si=1, net_di=64'hA5A5_0000_0000_0001 → net_ri drops next cycle; status read returns 1; addr 00 read returns the packet; net_ri=1 one cycle later.
- Write 64'h8000_0000_0000_00FF to addr 10 with net_ro=1 → net_so asserts only in the cycle net_polarity=1; net_do equals the packet; out_full=0 afterwards.
- Same as above with net_ro=0 for 5 cycles → net_so stays 0 and the packet is held; injection occurs on the first matching-polarity cycle after net_ro rises.
- Second write to addr 10 while full → out_buf unchanged; addr 11 reads 64'h3; a re-read reads 64'h1 (drop cleared).
- Router asserts net_si while in_full=1 with different data → in_buf keeps the first packet; no overwrite.
